// File: rtl/input_gather.sv
// Serial-to-parallel gather of eight WIDTH-bit words feeding an adder tree.
// Optional sum_valid delay line enabled by defining INPUT_GATHER_SUM_VALID_EN.
module input_gather #(
    parameter int WIDTH        = 16,
    parameter int TREE_LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] outputs [8],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sum_valid
);

    // Handshakes: a word moves when in_valid && in_ready, a group moves when
    // out_valid && out_ready; in_ready depends only on registered state.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [WIDTH-1:0] slot_q [8];
    logic [WIDTH-1:0] slot_d [8];
    logic             accept;
    logic             transfer;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        slot_d    = slot_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        transfer  = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    slot_d[count_q] = in_data;
                    count_d         = count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                out_valid = 1'b1;
                transfer  = out_ready;
                if (transfer) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign outputs = slot_q;

`ifdef INPUT_GATHER_SUM_VALID_EN
    // Bit i high means a transfer happened i+1 cycles ago.
    logic [TREE_LATENCY-1:0] sv_pipe_q, sv_pipe_d;

    always_comb begin
        sv_pipe_d    = '0;
        sv_pipe_d[0] = transfer;
        for (int i = 1; i < TREE_LATENCY; i++) begin
            sv_pipe_d[i] = sv_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv_pipe_q <= '0;
        end else begin
            sv_pipe_q <= sv_pipe_d;
        end
    end

    assign sum_valid = sv_pipe_q[TREE_LATENCY-1];
`else
    assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_input_gather.sv
// Self-checking bench for input_gather against a queue-based group model.
module tb_input_gather;

    localparam int W  = 16;
    localparam int TL = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] outputs [8];
    logic         out_valid;
    logic         out_ready;
    logic         sum_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    input_gather #(.WIDTH(W), .TREE_LATENCY(TL)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .outputs(outputs), .out_valid(out_valid),
        .out_ready(out_ready), .sum_valid(sum_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: words of the group being collected, the visible slot
    // contents, and whether a complete group is waiting.
    logic [W-1:0] grp_q[$];
    logic [W-1:0] m_out [8];
    bit           m_full;
    int           exp_sum_q[$];
    int           got_sum_q[$];
    int           got_xfer_q[$];

    always @(negedge clk) begin
        if (sum_valid === 1'b1) got_sum_q.push_back(cyc);
        if (out_valid === 1'b1 && out_ready === 1'b1) got_xfer_q.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        grp_q.delete();
        m_full = 1'b0;
        for (int i = 0; i < 8; i++) m_out[i] = '0;
    endtask

    // Drive one cycle, advance the model, return at #1 after the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (!m_full && v) begin
            m_out[grp_q.size()] = d;
            grp_q.push_back(d);
            if (grp_q.size() == 8) begin
                m_full = 1'b1;
                grp_q.delete();
            end
        end else if (m_full && r) begin
            m_full = 1'b0;
`ifdef INPUT_GATHER_SUM_VALID_EN
            exp_sum_q.push_back(cyc + TL);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid: got %b expected 0", sum_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outputs[i] !== '0) begin errors++; $display("FAIL reset_outputs[%0d]: got %0h expected 0", i, outputs[i]); end
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        for (int i = 0; i <= 8; i++) begin
            checks++;
            if (out_valid !== (i == 8)) begin errors++; $display("FAIL basic_out_valid c%0d: got %b expected %b", i, out_valid, (i == 8)); end
            checks++;
            if (in_ready !== (i != 8)) begin errors++; $display("FAIL basic_in_ready c%0d: got %b expected %b", i, in_ready, (i != 8)); end
            if (i == 8) begin
                for (int j = 0; j < 8; j++) begin
                    checks++;
                    if (outputs[j] !== W'(j + 1)) begin errors++; $display("FAIL basic_outputs[%0d]: got %0h expected %0h", j, outputs[j], j + 1); end
                end
            end
            cycle(1'b1, W'(i + 1), 1'b1);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_after_xfer: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int xfer_cyc;
        for (int k = 0; k < 8; k++) cycle(1'b1, W'(10 * (k + 1)), 1'b0);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold c%0d: got v=%b r=%b expected v=1 r=0", k, out_valid, in_ready);
            end
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (outputs[j] !== W'(10 * (j + 1))) begin errors++; $display("FAIL bp_outputs[%0d] c%0d: got %0d expected %0d", j, k, outputs[j], 10 * (j + 1)); end
            end
            if (k == 5) xfer_cyc = cyc;
            cycle(1'b1, W'($urandom), k == 5);
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", out_valid); end
        checks++;
        if (got_xfer_q.size() == 0 || got_xfer_q[$] != xfer_cyc) begin
            errors++; $display("FAIL bp_xfer_cycle: got %0d expected %0d", (got_xfer_q.size() == 0) ? -1 : got_xfer_q[$], xfer_cyc);
        end
    endtask

    task automatic test_toggle();
        logic [W-1:0] words[$];
        for (int k = 0; k < 15; k++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            if (k % 2 == 0) words.push_back(d);
            if (k == 14) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL toggle_early_full: got %b expected 0", out_valid); end
            end
            cycle(k % 2 == 0, d, 1'b1);
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL toggle_full: got %b expected 1", out_valid); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (outputs[j] !== words[j]) begin errors++; $display("FAIL toggle_outputs[%0d]: got %0h expected %0h", j, outputs[j], words[j]); end
        end
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int keep_q[$];
        for (int k = 0; k < 5; k++) cycle(1'b1, W'($urandom), 1'b1);
        #2;
        foreach (exp_sum_q[i]) if (exp_sum_q[i] < cyc) keep_q.push_back(exp_sum_q[i]);
        exp_sum_q = keep_q;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (outputs[j] !== '0) begin errors++; $display("FAIL midrst_outputs[%0d]: got %0h expected 0", j, outputs[j]); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) cycle(1'b1, W'(16'hA + k), 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_full: got %b expected 1", out_valid); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (outputs[j] !== W'(16'hA + j)) begin errors++; $display("FAIL midrst_group[%0d]: got %0h expected %0h", j, outputs[j], 16'hA + j); end
        end
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = got_xfer_q.size();
        for (int k = 0; k < 18; k++) cycle(1'b1, W'($urandom), 1'b1);
        checks++;
        if (got_xfer_q.size() != n0 + 2) begin
            errors++; $display("FAIL b2b_count: got %0d expected %0d", got_xfer_q.size() - n0, 2);
        end else begin
            checks++;
            if (got_xfer_q[n0 + 1] - got_xfer_q[n0] != 9) begin
                errors++; $display("FAIL b2b_spacing: got %0d expected 9", got_xfer_q[n0 + 1] - got_xfer_q[n0]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            checks++;
            if (out_valid !== m_full || in_ready !== !m_full) begin
                errors++; $display("FAIL rand_state k%0d: got v=%b r=%b expected v=%b r=%b", k, out_valid, in_ready, m_full, !m_full);
            end
            if (k % 8 == 0) begin
                for (int j = 0; j < 8; j++) begin
                    checks++;
                    if (outputs[j] !== m_out[j]) begin errors++; $display("FAIL rand_outputs[%0d] k%0d: got %0h expected %0h", j, k, outputs[j], m_out[j]); end
                end
            end
            cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0);
        end
    endtask

    task automatic test_sum_valid();
        repeat (TL + 2) cycle(1'b0, '0, 1'b0);
        checks++;
        if (got_sum_q.size() != exp_sum_q.size()) begin
            errors++; $display("FAIL sum_count: got %0d expected %0d", got_sum_q.size(), exp_sum_q.size());
        end else begin
            foreach (exp_sum_q[i]) begin
                checks++;
                if (got_sum_q[i] != exp_sum_q[i]) begin errors++; $display("FAIL sum_cycle[%0d]: got %0d expected %0d", i, got_sum_q[i], exp_sum_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_sum_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
